// File: rtl/mem_pkg.sv
// Shared types and boot image for sync_program_memory: FSM states, boot entry layout
// and the table written by the optional preload phase.
package mem_pkg;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    PRELOAD = 2'd1,
    READY   = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } boot_entry_t;

  localparam int BOOT_LEN = 8;

  localparam boot_entry_t BOOT_IMAGE [BOOT_LEN] = '{
    '{addr: 16'd0,   data: 8'hF9},
    '{addr: 16'd1,   data: 8'h00},
    '{addr: 16'd2,   data: 8'h7F},
    '{addr: 16'd3,   data: 8'h20},
    '{addr: 16'd4,   data: 8'hFF},
    '{addr: 16'd5,   data: 8'h60},
    '{addr: 16'd6,   data: 8'hFF},
    '{addr: 16'd127, data: 8'h1E}
  };

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-latency shift register: STAGES data+valid stages with synchronous flush.
// Each stage's data only advances alongside a valid, so the output holds between strobes.
module mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [STAGES-1:0] valid_q;
  logic [DATA_W-1:0] data_q [STAGES];

  always_ff @(posedge clk) begin
    if (flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/sync_program_memory.sv
// Program memory that self-clears after reset, optionally loads a boot image
// (macro MEM_PRELOAD_EN), then serves reads with RD_LAT cycles of latency.
module sync_program_memory
  import mem_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] command,
  output logic              cmd_valid,
  output logic              ready
);

  localparam int DEPTH = 2**ADDR_W;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
`ifdef MEM_PRELOAD_EN
  localparam int BIDX_W = $clog2(BOOT_LEN);
  logic [BIDX_W-1:0] boot_idx_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
`ifdef MEM_PRELOAD_EN
      boot_idx_q <= '0;
`endif
    end else begin
      case (state_q)
        CLEAR: begin
          // Hold the pointer on the last word instead of wrapping back to 0.
          if (clr_ptr_q == '1) begin
`ifdef MEM_PRELOAD_EN
            state_q <= PRELOAD;
`else
            state_q <= READY;
`endif
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
`ifdef MEM_PRELOAD_EN
        PRELOAD: begin
          if (boot_idx_q == BIDX_W'(BOOT_LEN-1)) state_q <= READY;
          else                                   boot_idx_q <= boot_idx_q + 1'b1;
        end
`endif
        READY:   ;
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign ready = (state_q == READY);

  // Single write port shared by clear, preload and user writes.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = write_data;
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          wr_en   = 1'b1;
          wr_addr = clr_ptr_q;
          wr_data = '0;
        end
`ifdef MEM_PRELOAD_EN
        PRELOAD: begin
          wr_en   = 1'b1;
          wr_addr = ADDR_W'(BOOT_IMAGE[boot_idx_q].addr);
          wr_data = DATA_W'(BOOT_IMAGE[boot_idx_q].data);
        end
`endif
        READY:   wr_en = mem_write;
        default: wr_en = 1'b0;
      endcase
    end
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch; the CLEAR state zeroes it word by word.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Reading the array before the same edge's write lands gives old-data semantics.
  logic rd_accept;
  assign rd_accept = mem_read && !rst && (state_q == READY);

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .flush_i (rst),
    .valid_i (rd_accept),
    .data_i  (mem_q[address]),
    .valid_o (cmd_valid),
    .data_o  (command)
  );

endmodule

// File: tb/tb_sync_program_memory.sv
// Directed bench for sync_program_memory; define MEM_PRELOAD_EN to run the boot-image
// variant (ADDR_W=13) instead of the default clear/read/reset suite (ADDR_W=4).
module tb_sync_program_memory;
  import mem_pkg::*;

`ifdef MEM_PRELOAD_EN
  localparam int AW = 13;
`else
  localparam int AW = 4;
`endif
  localparam int DW     = 8;
  localparam int LAT    = 3;
  localparam int DEPTH  = 2**AW;
  localparam int LIMIT  = DEPTH + BOOT_LEN + 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] command;
  logic          cmd_valid;
  logic          ready;

  int n_vec = 0;
  int n_bad = 0;

  sync_program_memory #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .write_data (write_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .command    (command),
    .cmd_valid  (cmd_valid),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges with rst low until ready rises; any strobe seen meanwhile is an error.
  task automatic wait_ready(input string tag, input int exp_edges);
    int   cnt  = 0;
    logic seen = 1'b0;
    while (!ready && cnt < LIMIT) begin
      step();
      cnt++;
      if (cmd_valid) seen = 1'b1;
    end
    check({tag, "_edges"}, cnt, exp_edges);
    check({tag, "_nostrobe"}, {31'd0, seen}, 32'd0);
  endtask

  // One read (optionally with a same-edge write); strobe must appear only LAT-1 edges later.
  task automatic xfer(input string tag, input logic [AW-1:0] a, input logic wr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp);
    address    = a;
    mem_write  = wr;
    write_data = wd;
    mem_read   = 1'b1;
    step();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      if (j > 0) step();
      check($sformatf("%s_vld%0d", tag, j), {31'd0, cmd_valid}, (j == LAT-1) ? 32'd1 : 32'd0);
    end
    check({tag, "_cmd"}, command, exp);
    step();
    check({tag, "_vld_drop"}, {31'd0, cmd_valid}, 32'd0);
    check({tag, "_hold"}, command, exp);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    address    = a;
    write_data = d;
    mem_write  = 1'b1;
    step();
    mem_write  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    address    = '0;
    write_data = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_vld", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd", command, 32'd0);
    rst = 1'b0;

`ifdef MEM_PRELOAD_EN
    wait_ready("boot", DEPTH + BOOT_LEN);
    xfer("boot_a0", 13'd0, 1'b0, 8'h00, 8'hF9);
    xfer("boot_a2", 13'd2, 1'b0, 8'h00, 8'h7F);
    xfer("boot_a127", 13'd127, 1'b0, 8'h00, 8'h1E);
    xfer("boot_a200", 13'd200, 1'b0, 8'h00, 8'h00);
`else
    // Clear phase: ready low for exactly DEPTH edges; a write/read mid-clear is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("clr_ready%0d", i), {31'd0, ready}, 32'd0);
      if (i == 8) begin
        address    = 4'd2;
        write_data = 8'h55;
        mem_write  = 1'b1;
        mem_read   = 1'b1;
      end
      step();
      mem_write = 1'b0;
      mem_read  = 1'b0;
      check($sformatf("clr_vld%0d", i), {31'd0, cmd_valid}, 32'd0);
    end
    check("clr_ready_up", {31'd0, ready}, 32'd1);

    // Back-to-back reads of every word: strobes back to back, all zero.
    for (int k = 0; k < DEPTH + LAT - 1; k++) begin
      mem_read = (k < DEPTH);
      address  = AW'(k);
      step();
      if (k >= LAT - 1) begin
        check($sformatf("all_vld%0d", k), {31'd0, cmd_valid}, 32'd1);
        check($sformatf("all_cmd%0d", k), command, 32'd0);
      end else begin
        check($sformatf("all_vld%0d", k), {31'd0, cmd_valid}, 32'd0);
      end
    end
    mem_read = 1'b0;
    step();
    check("all_vld_end", {31'd0, cmd_valid}, 32'd0);

    xfer("blocked_wr", 4'd2, 1'b0, 8'h00, 8'h00);

    write_word(4'd5, 8'hA5);
    xfer("lat3", 4'd5, 1'b0, 8'h00, 8'hA5);

    write_word(4'd3, 8'h11);
    xfer("rw_old", 4'd3, 1'b1, 8'h22, 8'h11);
    xfer("rw_new", 4'd3, 1'b0, 8'h00, 8'h22);

    // Reset mid-clear at clr_ptr = 9.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("midclr_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready("midclr", DEPTH);

    // Reset with two reads in flight.
    write_word(4'd5, 8'h5A);
    address  = 4'd5;
    mem_read = 1'b1;
    step();
    address  = 4'd3;
    step();
    mem_read = 1'b0;
    rst      = 1'b1;
    step();
    check("flush_vld", {31'd0, cmd_valid}, 32'd0);
    check("flush_cmd", command, 32'd0);
    check("flush_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    wait_ready("flush", DEPTH);
    xfer("post_flush", 4'd5, 1'b0, 8'h00, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_program_memory.md
SYNC_PROGRAM_MEMORY -- requirements
Module: sync_program_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, address width; depth DEPTH = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 8, word width.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port address, input, ADDR_W, read/write word address.
REQ-007 SHALL have port write_data, input, DATA_W, write word.
REQ-008 SHALL have port mem_read, input, 1, read request.
REQ-009 SHALL have port mem_write, input, 1, write request.
REQ-010 SHALL have port command, output, DATA_W, registered read data.
REQ-011 SHALL have port cmd_valid, output, 1, one-cycle strobe marking new command.
REQ-012 SHALL have port ready, output, 1, high only in state READY.

Function
REQ-013 SHALL implement FSM states CLEAR, PRELOAD, READY; ready decoded from state register.
REQ-014 CLEAR SHALL write 0 to mem[clr_ptr] and increment clr_ptr on each edge with rst low, starting at 0.
REQ-015 CLEAR SHALL transition on the edge that writes mem[DEPTH-1]: to PRELOAD if MEM_PRELOAD_EN is defined, else to READY.
REQ-016 clr_ptr SHALL be exactly ADDR_W bits wide; no wrap past DEPTH-1 occurs.
REQ-017 In READY, mem_write high at an edge SHALL write write_data to mem[address] at that edge.
REQ-018 In READY, a mem_read high at edge N SHALL be accepted; command and cmd_valid SHALL update at edge N+RD_LAT-1.
REQ-019 One read SHALL be accepted per cycle; back-to-back reads SHALL yield back-to-back cmd_valid strobes in order.
REQ-020 mem_read and mem_write at the same edge and address SHALL return the pre-write (old) data.
REQ-021 command SHALL hold its last value when cmd_valid is low.
REQ-022 mem_read/mem_write while ready is low SHALL be ignored: no write, no strobe, no queueing.

Reset
REQ-023 rst high at any edge SHALL force state CLEAR, clr_ptr 0, command 0, cmd_valid 0, ready 0, and flush all in-flight reads.
REQ-024 While rst stays high, no clearing progress SHALL occur; clearing starts at the first edge with rst low.
REQ-025 Reset mid-CLEAR, mid-PRELOAD or with reads in flight SHALL restart clearing from address 0 with no cmd_valid for flushed reads.

Configuration
REQ-026 Macro MEM_PRELOAD_EN SHALL enable PRELOAD.
REQ-027 With MEM_PRELOAD_EN, PRELOAD SHALL write one BOOT_IMAGE entry {addr, data} per edge, index 0..BOOT_LEN-1, then enter READY.
REQ-028 With MEM_PRELOAD_EN, ready SHALL rise DEPTH+BOOT_LEN edges after rst deasserts; without it, DEPTH edges.
REQ-029 Without MEM_PRELOAD_EN, the PRELOAD state, boot index and table logic SHALL be absent; memory reads 0 everywhere after clear.

Structure
REQ-030 Package mem_pkg SHALL hold the FSM state enum, the boot entry struct, BOOT_LEN and the BOOT_IMAGE constant array.
REQ-031 BOOT_IMAGE default SHALL be: 0:8'hF9, 1:8'h00, 2:8'h7F, 3:8'h20, 4:8'hFF, 5:8'h60, 6:8'hFF, 127:8'h1E.
REQ-032 Read-latency delay SHALL be a sub-module mem_rd_pipe (RD_LAT-stage data+valid shift register with synchronous flush).

Verification (bench uses ADDR_W=4, DATA_W=8)
REQ-033 rst 1 cycle then low -> ready low for 16 edges, high after; all 16 reads return 8'h00 (no macro).
REQ-034 RD_LAT=3: write 8'hA5 to addr 5, read addr 5 at edge N -> command 8'hA5, cmd_valid high only at edge N+2.
REQ-035 Same-edge read+write addr 3 (old 8'h11, new 8'h22) -> command 8'h11; next read of addr 3 -> 8'h22.
REQ-036 Write 8'h55 to addr 2 while ready low -> no effect; read addr 2 after ready -> 8'h00.
REQ-037 rst pulsed at clr_ptr=9 and again with 2 reads in flight -> no cmd_valid for flushed reads; ready returns exactly 16 edges after rst low.
REQ-038 MEM_PRELOAD_EN, ADDR_W=13: ready after 8192+8 edges; read addr 0 -> 8'hF9, addr 127 -> 8'h1E, addr 200 -> 8'h00.
